cci_mpf_shim_wro_count_filter: RTL
==================================

CCI_MPF_SHIM_WRO_COUNT_FILTER -- requirements
Module: cci_mpf_shim_wro_count_filter

Interface
REQ-001 SHALL have parameter HASH_BITS, default 14, address-hash width; filter depth 2^HASH_BITS.
REQ-002 SHALL have parameter CNT_BITS, default 4, per-entry counter width.
REQ-003 SHALL have parameter MAX_ACTIVE_REQS, default 128, bound on the active_reqs counter.
REQ-004 SHALL have ports, in order:
- clk  in  1  sole clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low.
- ordering_mode  in  2  0=bypass, 1=WAW only, 2=WAW+RAW+WAR, 3=reserved, treated as 2.
- init_done  out  1  filter cleared, accepting traffic.
- ins_valid  in  1  lookup-and-insert request.
- ins_hash  in  HASH_BITS  request address hash.
- ins_is_write  in  1  1=write, 0=read.
- ins_rsp_valid  out  1  insert result valid.
- ins_rsp_granted  out  1  1=inserted, 0=conflict, not inserted.
- rem_valid  in  1  completion, remove one entry.
- rem_hash  in  HASH_BITS  completion hash.
- rem_is_write  in  1  completion type.
- active_reqs  out  $clog2(MAX_ACTIVE_REQS+1)  granted minus removed.
- conflict_pulse  out  1  one-cycle pulse per denied insert.
- err_underflow  out  1  sticky removal-of-zero error.

Function
REQ-005 SHALL keep two counter arrays, RCNT and WCNT, each 2^HASH_BITS x CNT_BITS, read with one-cycle registered latency.
REQ-006 SHALL use FSM states INIT and READY; reset enters INIT; INIT writes zero to index 0..2^HASH_BITS-1 of both arrays, one index per cycle, then enters READY.
REQ-007 SHALL drive init_done=1 only in READY; ins_valid and rem_valid in INIT SHALL be ignored with no response.
REQ-008 SHALL produce, for ins_valid at cycle T in READY, ins_rsp_valid=1 at exactly T+2, one response per request, in request order, one request per cycle sustained.
REQ-009 SHALL deny in mode 1 if WCNT[h]!=0 and ins_is_write=1; in mode 2 deny a write if WCNT[h]!=0 or RCNT[h]!=0, deny a read if WCNT[h]!=0; in mode 0 never deny for hazard.
REQ-010 SHALL deny in every mode if the target counter equals 2^CNT_BITS-1 (saturation).
REQ-011 SHALL, on grant, increment the counter selected by ins_is_write and increment active_reqs; on deny, change nothing and pulse conflict_pulse at T+2.
REQ-012 SHALL, for rem_valid at cycle T, decrement the counter selected by rem_is_write and decrement active_reqs, with no response.
REQ-013 SHALL, on removal from a zero counter, leave it at zero, leave active_reqs unchanged, and set err_underflow until reset.
REQ-014 SHALL forward pending stage-2 counter updates to stage-1 reads of the same index, so back-to-back requests to one hash see the previous result.
REQ-015 SHALL apply insert and remove to the same counter in the same cycle as a net change: +1-1=0, no underflow flagged if the pre-value was nonzero after the increment.
REQ-016 SHALL track counters in all modes, so mode changes never corrupt state; a new mode applies to requests presented after the change.
REQ-017 SHALL saturate active_reqs at MAX_ACTIVE_REQS and zero.

Reset
REQ-018 SHALL, on reset assertion at any time, clear ins_rsp_valid, ins_rsp_granted, conflict_pulse, err_underflow, init_done and active_reqs to 0 asynchronously, discard in-flight requests, and restart INIT on deassertion.

Verification
REQ-019 Reset release with HASH_BITS=4 -> init_done=0 for 16 cycles, 1 on cycle 17; ins_valid during INIT -> no ins_rsp_valid.
REQ-020 Mode 2: write h=5 at T, write h=5 at T+1 -> T+2 granted=1, T+3 granted=0, conflict_pulse=1, active_reqs=1.
REQ-021 Mode 2: reads h=7 at T, T+1, T+2 -> all granted, RCNT[7]=3; write h=7 at T+3 denied; three removals of read h=7, then write h=7 -> granted.
REQ-022 CNT_BITS=2, mode 0: four reads h=3 -> first three granted, fourth denied (saturation).
REQ-023 Remove write h=9 with WCNT[9]=0 -> err_underflow=1 and held, active_reqs unchanged; reset -> err_underflow=0.
REQ-024 Insert write h=2 and remove write h=2 in the same cycle with WCNT[2]=1 -> granted, WCNT[2]=1, active_reqs unchanged; reset mid-stream -> outputs 0 immediately, INIT restarts.

Source files
------------

// File: rtl/cci_mpf_shim_wro_count_filter.sv
// Write-ordering count filter: per-hash read/write counters gate new requests
// against outstanding ones through a two-stage pipeline with same-index forwarding.
module cci_mpf_shim_wro_count_filter #(
  parameter int HASH_BITS       = 14,
  parameter int CNT_BITS        = 4,
  parameter int MAX_ACTIVE_REQS = 128
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [1:0]                           ordering_mode,
  output logic                                 init_done,
  input  logic                                 ins_valid,
  input  logic [HASH_BITS-1:0]                 ins_hash,
  input  logic                                 ins_is_write,
  output logic                                 ins_rsp_valid,
  output logic                                 ins_rsp_granted,
  input  logic                                 rem_valid,
  input  logic [HASH_BITS-1:0]                 rem_hash,
  input  logic                                 rem_is_write,
  output logic [$clog2(MAX_ACTIVE_REQS+1)-1:0] active_reqs,
  output logic                                 conflict_pulse,
  output logic                                 err_underflow
);
  localparam int DEPTH = 1 << HASH_BITS;
  localparam int AW    = $clog2(MAX_ACTIVE_REQS + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
  localparam logic [AW-1:0]       ACT_MAX = AW'(MAX_ACTIVE_REQS);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [HASH_BITS-1:0] r_init_idx;
  logic [CNT_BITS-1:0]  r_rcnt [DEPTH];
  logic [CNT_BITS-1:0]  r_wcnt [DEPTH];

  logic                 r_s1_ins_vld, r_s1_ins_wr, r_s1_rem_vld, r_s1_rem_wr;
  logic [HASH_BITS-1:0] r_s1_ins_hash, r_s1_rem_hash;
  logic [1:0]           r_s1_mode;
  logic [CNT_BITS-1:0]  r_s1_ins_rcnt, r_s1_ins_wcnt, r_s1_rem_rcnt, r_s1_rem_wcnt;

  logic                 w_ready, w_hazard, w_grant, w_same, w_underflow;
  logic                 w_ins_we, w_rem_we, w_act_inc, w_act_dec;
  logic [CNT_BITS-1:0]  w_ins_old, w_rem_old, w_ins_val, w_rem_val;
  logic [AW-1:0]        w_act_nxt;

  logic                 r_init_done, r_rsp_vld, r_rsp_gnt, r_conflict, r_err;
  logic [AW-1:0]        r_act;

  // A counter read sees the stage-2 update committing on the same edge.
  function automatic logic [CNT_BITS-1:0] f_fwd(
    input logic [CNT_BITS-1:0]  mem_val,
    input logic [HASH_BITS-1:0] idx,
    input logic                 arr_w,
    input logic                 ins_we,
    input logic [HASH_BITS-1:0] ins_idx,
    input logic                 ins_w,
    input logic [CNT_BITS-1:0]  ins_val,
    input logic                 rem_we,
    input logic [HASH_BITS-1:0] rem_idx,
    input logic                 rem_w,
    input logic [CNT_BITS-1:0]  rem_val
  );
    logic [CNT_BITS-1:0] v;
    if (rem_we && (rem_w == arr_w) && (rem_idx == idx)) begin
      v = rem_val;
    end else if (ins_we && (ins_w == arr_w) && (ins_idx == idx)) begin
      v = ins_val;
    end else begin
      v = mem_val;
    end
    return v;
  endfunction

  assign w_ready = (r_state == ST_READY);

  // State register and clear-index walk
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_INIT;
      r_init_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) begin
        r_init_idx <= r_init_idx + HASH_BITS'(1);
      end else begin
        r_init_idx <= '0;
      end
    end
  end

  // Next-state: leave INIT after the last index is cleared
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: begin
        if (r_init_idx == {HASH_BITS{1'b1}}) begin
          w_state_nxt = ST_READY;
        end else begin
          w_state_nxt = ST_INIT;
        end
      end
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  // Stage 1: capture requests with forwarded counter reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_ins_vld  <= 1'b0;
      r_s1_rem_vld  <= 1'b0;
      r_s1_ins_wr   <= 1'b0;
      r_s1_rem_wr   <= 1'b0;
      r_s1_ins_hash <= '0;
      r_s1_rem_hash <= '0;
      r_s1_mode     <= 2'd0;
      r_s1_ins_rcnt <= '0;
      r_s1_ins_wcnt <= '0;
      r_s1_rem_rcnt <= '0;
      r_s1_rem_wcnt <= '0;
    end else begin
      r_s1_ins_vld  <= w_ready && ins_valid;
      r_s1_rem_vld  <= w_ready && rem_valid;
      r_s1_ins_wr   <= ins_is_write;
      r_s1_rem_wr   <= rem_is_write;
      r_s1_ins_hash <= ins_hash;
      r_s1_rem_hash <= rem_hash;
      r_s1_mode     <= ordering_mode;
      r_s1_ins_rcnt <= f_fwd(r_rcnt[ins_hash], ins_hash, 1'b0, w_ins_we, r_s1_ins_hash,
                             r_s1_ins_wr, w_ins_val, w_rem_we, r_s1_rem_hash, r_s1_rem_wr, w_rem_val);
      r_s1_ins_wcnt <= f_fwd(r_wcnt[ins_hash], ins_hash, 1'b1, w_ins_we, r_s1_ins_hash,
                             r_s1_ins_wr, w_ins_val, w_rem_we, r_s1_rem_hash, r_s1_rem_wr, w_rem_val);
      r_s1_rem_rcnt <= f_fwd(r_rcnt[rem_hash], rem_hash, 1'b0, w_ins_we, r_s1_ins_hash,
                             r_s1_ins_wr, w_ins_val, w_rem_we, r_s1_rem_hash, r_s1_rem_wr, w_rem_val);
      r_s1_rem_wcnt <= f_fwd(r_wcnt[rem_hash], rem_hash, 1'b1, w_ins_we, r_s1_ins_hash,
                             r_s1_ins_wr, w_ins_val, w_rem_we, r_s1_rem_hash, r_s1_rem_wr, w_rem_val);
    end
  end

  // Stage 2: hazard decision and counter updates; mode 3 behaves as mode 2
  always_comb begin
    w_ins_old = r_s1_ins_wr ? r_s1_ins_wcnt : r_s1_ins_rcnt;
    w_rem_old = r_s1_rem_wr ? r_s1_rem_wcnt : r_s1_rem_rcnt;
    case (r_s1_mode)
      2'd0:    w_hazard = 1'b0;
      2'd1:    w_hazard = r_s1_ins_wr && (r_s1_ins_wcnt != '0);
      default: w_hazard = (r_s1_ins_wcnt != '0) || (r_s1_ins_wr && (r_s1_ins_rcnt != '0));
    endcase
    w_grant = r_s1_ins_vld && !w_hazard && (w_ins_old != CNT_MAX);
    w_same  = w_grant && r_s1_rem_vld && (r_s1_ins_hash == r_s1_rem_hash) &&
              (r_s1_ins_wr == r_s1_rem_wr);
    w_ins_we    = w_grant;
    w_rem_we    = 1'b0;
    w_underflow = 1'b0;
    w_rem_val   = w_rem_old - CNT_BITS'(1);
    if (w_same) begin
      w_ins_val = w_ins_old;
    end else begin
      w_ins_val = w_ins_old + CNT_BITS'(1);
    end
    if (r_s1_rem_vld && !w_same) begin
      if (w_rem_old == '0) begin
        w_underflow = 1'b1;
      end else begin
        w_rem_we = 1'b1;
      end
    end else begin
      w_rem_we = 1'b0;
    end
    w_act_inc = w_grant && !w_same;
    w_act_dec = w_rem_we;
  end

  // Outstanding-request count, clamped to [0, MAX_ACTIVE_REQS]
  always_comb begin
    w_act_nxt = r_act;
    if (w_act_inc && !w_act_dec) begin
      if (r_act < ACT_MAX) begin
        w_act_nxt = r_act + AW'(1);
      end else begin
        w_act_nxt = ACT_MAX;
      end
    end else if (w_act_dec && !w_act_inc) begin
      if (r_act != '0) begin
        w_act_nxt = r_act - AW'(1);
      end else begin
        w_act_nxt = '0;
      end
    end else begin
      w_act_nxt = r_act;
    end
  end

  // Counter arrays: cleared during INIT, updated from stage 2 in READY
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_rcnt[r_init_idx] <= '0;
      r_wcnt[r_init_idx] <= '0;
    end else begin
      if (w_ins_we) begin
        if (r_s1_ins_wr) begin
          r_wcnt[r_s1_ins_hash] <= w_ins_val;
        end else begin
          r_rcnt[r_s1_ins_hash] <= w_ins_val;
        end
      end
      if (w_rem_we) begin
        if (r_s1_rem_wr) begin
          r_wcnt[r_s1_rem_hash] <= w_rem_val;
        end else begin
          r_rcnt[r_s1_rem_hash] <= w_rem_val;
        end
      end
    end
  end

  // Registered outputs; underflow error is sticky until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_init_done <= 1'b0;
      r_rsp_vld   <= 1'b0;
      r_rsp_gnt   <= 1'b0;
      r_conflict  <= 1'b0;
      r_err       <= 1'b0;
      r_act       <= '0;
    end else begin
      r_init_done <= (w_state_nxt == ST_READY);
      r_rsp_vld   <= r_s1_ins_vld;
      r_rsp_gnt   <= w_grant;
      r_conflict  <= r_s1_ins_vld && !w_grant;
      r_err       <= r_err || w_underflow;
      r_act       <= w_act_nxt;
    end
  end

  assign init_done       = r_init_done;
  assign ins_rsp_valid   = r_rsp_vld;
  assign ins_rsp_granted = r_rsp_gnt;
  assign conflict_pulse  = r_conflict;
  assign err_underflow   = r_err;
  assign active_reqs     = r_act;

endmodule
